addr_sequencer: RTL and testbench
=================================

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter START_ADDR, default 23'h000000, first word address of the audio region.
REQ-002 Parameter END_ADDR, default 23'h07FFFF, last word address of the audio region; END_ADDR >= START_ADDR.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 key_play  in  1  single-cycle pulse; request playback.
REQ-006 key_pause  in  1  single-cycle pulse; request pause.
REQ-007 key_restart  in  1  single-cycle pulse; jump to the start point for the current direction.
REQ-008 dir_reverse  in  1  level; 1 = play backward, 0 = play forward.
REQ-009 new_value_read  in  1  single-cycle pulse from the downstream flash-read stage; one audio sample consumed.
REQ-010 mem_address  out  23  word address presented to the downstream flash-read stage.
REQ-011 pause  out  1  1 when not in PLAY; downstream stage mutes output.
REQ-012 reverse  out  1  registered copy of dir_reverse, updated only at word boundaries.
REQ-013 end_reached  out  1  single-cycle pulse when the address passes a region boundary.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and PLAY.
REQ-015 IDLE -> PLAY on key_play; PLAY -> IDLE on key_pause; key_play and key_pause in the same cycle SHALL give pause priority.
REQ-016 pause SHALL be registered: 1 in IDLE, 0 in PLAY, changing on the edge that changes state.
REQ-017 Each word holds two 8-bit samples; a 1-bit half counter SHALL toggle on each new_value_read accepted in PLAY.
REQ-018 new_value_read received in IDLE SHALL be ignored (no half or address change).
REQ-019 On an accepted new_value_read with half = 1, mem_address SHALL step by one word on that same edge and half SHALL return to 0.
REQ-020 Forward step: mem_address + 1; at END_ADDR, next address is START_ADDR.
REQ-021 Reverse step: mem_address - 1; at START_ADDR, next address is END_ADDR.
REQ-022 end_reached SHALL pulse high for exactly one cycle on the edge where a wrap (REQ-020/021) occurs.
REQ-023 reverse SHALL sample dir_reverse only on the edge when half returns to 0, or in IDLE, so one word is never split across directions.
REQ-024 key_restart SHALL set mem_address to START_ADDR (reverse = 0) or END_ADDR (reverse = 1), clear half, leave FSM state unchanged, and not pulse end_reached.
REQ-025 key_restart coincident with new_value_read SHALL take priority; the read pulse is discarded.
REQ-026 Address arithmetic SHALL be 23-bit unsigned; no value outside [START_ADDR, END_ADDR] SHALL ever appear on mem_address.
REQ-027 mem_address latency: new value visible one clk after the triggering edge input is sampled.

Reset
REQ-028 reset_n low SHALL immediately force state = IDLE, mem_address = START_ADDR, half = 0, pause = 1, reverse = 0, end_reached = 0.
REQ-029 reset_n assertion mid-playback SHALL abandon the current word; after release the block waits in IDLE for key_play.
REQ-030 reset_n deassertion is synchronous to clk externally; no internal synchroniser is required.

Configuration
REQ-031 Macro ADDR_SEQ_LOOP_EN defined: boundary wraps per REQ-020/021 and PLAY continues.
REQ-032 ADDR_SEQ_LOOP_EN undefined: at the boundary mem_address SHALL hold at END_ADDR (forward) or START_ADDR (reverse), end_reached pulses once, and FSM goes to IDLE on that same edge.

Verification
REQ-033 Reset, key_play, 4 new_value_read pulses forward -> mem_address 0,0,1,1,2; pause 1 -> 0 one clk after key_play.
REQ-034 Play from END_ADDR-1 forward, 4 read pulses, LOOP_EN defined -> addresses 7FFFE, 7FFFF, 00000; end_reached single pulse at wrap; undefined -> holds 7FFFF, pause = 1.
REQ-035 dir_reverse raised after first read pulse at address 5 -> second pulse steps to 6, then reverse = 1 and next word steps to 5.
REQ-036 key_restart with dir_reverse = 1 coincident with new_value_read at address 10 -> mem_address = END_ADDR, half = 0, state PLAY.
REQ-037 key_play and key_pause same cycle from IDLE -> stays IDLE, pause = 1; read pulses ignored.
REQ-038 reset_n asserted at address 0x1234 half = 1 mid-cycle -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/addr_sequencer.sv
// addr_sequencer: walks a flash word address through [START_ADDR, END_ADDR], two 8-bit samples per word.
// Build option ADDR_SEQ_LOOP_EN: wrap at region boundaries and keep playing; otherwise stop at the boundary.
module addr_sequencer #(
   parameter logic [22:0] START_ADDR = 23'h000000,
   parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        key_play,
   input  logic        key_pause,
   input  logic        key_restart,
   input  logic        dir_reverse,
   input  logic        new_value_read,
   output logic [22:0] mem_address,
   output logic        pause,
   output logic        reverse,
   output logic        end_reached
);

`ifdef ADDR_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   state_t state, state_nxt;
   logic   half;
   logic   accept, step, at_bound, hit_end;

   // restart wins over a coincident read; reads outside PLAY are dropped
   assign accept   = (state == PLAY) && new_value_read && !key_restart;
   assign step     = accept && half;
   assign at_bound = reverse ? (mem_address == START_ADDR) : (mem_address == END_ADDR);
   assign hit_end  = step && at_bound;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == IDLE) begin
         if (key_play && !key_pause) state_nxt = PLAY;
      end else begin
         if (key_pause)               state_nxt = IDLE;
         else if (hit_end && !LOOP_EN) state_nxt = IDLE;
      end
   end

   // state is a single flop, so pause is a direct register output
   always_comb begin
      pause = (state == IDLE);
   end

   // direction is only re-sampled at a word boundary (or restart / IDLE) so a word never splits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_address <= START_ADDR;
         half        <= 1'b0;
         reverse     <= 1'b0;
         end_reached <= 1'b0;
      end else begin
         end_reached <= hit_end;
         if (key_restart) begin
            mem_address <= dir_reverse ? END_ADDR : START_ADDR;
            half        <= 1'b0;
            reverse     <= dir_reverse;
         end else if (accept) begin
            half <= ~half;
            if (half) begin
               reverse <= dir_reverse;
               if (!at_bound)
                  mem_address <= reverse ? (mem_address - 23'd1) : (mem_address + 23'd1);
               else if (LOOP_EN)
                  mem_address <= reverse ? END_ADDR : START_ADDR;
            end
         end else if (state == IDLE) begin
            reverse <= dir_reverse;
         end
      end
   end

endmodule

// File: tb/tb_addr_sequencer.sv
// tb_addr_sequencer: directed scenarios plus randomized run against a word-offset playback model.
// Honours ADDR_SEQ_LOOP_EN the same way the design does.
module tb_addr_sequencer;

   localparam logic [22:0] S = 23'h000000;
   localparam logic [22:0] E = 23'h07FFFF;
   localparam int          N = int'(E) - int'(S) + 1;
`ifdef ADDR_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        key_play = 1'b0, key_pause = 1'b0, key_restart = 1'b0;
   logic        dir_reverse = 1'b0, new_value_read = 1'b0;
   logic [22:0] mem_address;
   logic        pause, reverse, end_reached;

   int errors = 0;
   int checks = 0;

   // model: playing flag, sample half, direction, word offset into region
   bit m_play, m_half, m_rev, m_end;
   int m_off;

   addr_sequencer #(.START_ADDR(S), .END_ADDR(E)) dut (
      .clk(clk), .reset_n(reset_n), .key_play(key_play), .key_pause(key_pause),
      .key_restart(key_restart), .dir_reverse(dir_reverse), .new_value_read(new_value_read),
      .mem_address(mem_address), .pause(pause), .reverse(reverse), .end_reached(end_reached)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_play = 0; m_half = 0; m_rev = 0; m_end = 0; m_off = 0;
   endfunction

   function automatic void model_step();
      bit nxt_play;
      int off;
      m_end    = 0;
      nxt_play = m_play ? !key_pause : (key_play && !key_pause);
      if (key_restart) begin
         m_rev  = dir_reverse;
         m_off  = dir_reverse ? N - 1 : 0;
         m_half = 0;
      end else if (m_play && new_value_read) begin
         if (!m_half) m_half = 1;
         else begin
            m_half = 0;
            off = m_rev ? m_off - 1 : m_off + 1;
            if (off < 0 || off >= N) begin
               m_end = 1;
               if (LOOP) m_off = (off + N) % N;
               else      nxt_play = 0;
            end else m_off = off;
            m_rev = dir_reverse;
         end
      end else if (!m_play) begin
         m_rev = dir_reverse;
      end
      m_play = nxt_play;
   endfunction

   // one clock: drive inputs, advance model on the edge, leave #1 after it
   task automatic cycle(input bit p, input bit pa, input bit rs, input bit d, input bit n);
      key_play = p; key_pause = pa; key_restart = rs; dir_reverse = d; new_value_read = n;
      @(posedge clk);
      model_step();
      #1;
      key_play = 0; key_pause = 0; key_restart = 0; new_value_read = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 0; dir_reverse = 0;
      model_reset();
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      if (mem_address !== S)   begin errors++; $display("FAIL reset_addr got=%h exp=%h", mem_address, S); end
      if (pause !== 1'b1)      begin errors++; $display("FAIL reset_pause got=%b exp=1", pause); end
      if (reverse !== 1'b0)    begin errors++; $display("FAIL reset_reverse got=%b exp=0", reverse); end
      if (end_reached !== 1'b0) begin errors++; $display("FAIL reset_end got=%b exp=0", end_reached); end
      checks += 4;
   endtask

   task automatic test_forward();
      logic [22:0] exp [5] = '{23'd0, 23'd0, 23'd1, 23'd1, 23'd2};
      do_reset();
      cycle(1, 0, 0, 0, 0);
      if (pause !== 1'b0) begin errors++; $display("FAIL fwd_pause got=%b exp=0", pause); end
      checks++;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cycle(0, 0, 0, 0, 1);
         if (mem_address !== exp[i]) begin errors++; $display("FAIL fwd_addr%0d got=%h exp=%h", i, mem_address, exp[i]); end
         checks++;
      end
   endtask

   task automatic test_wrap();
      logic [22:0] exp [4] = '{E - 23'd1, E, E, (LOOP ? S : E)};
      do_reset();
      cycle(0, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      if (mem_address !== E - 23'd1 || reverse !== 1'b0) begin
         errors++; $display("FAIL wrap_setup got=%h/%b exp=%h/0", mem_address, reverse, E - 23'd1);
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 0, 1);
         if (mem_address !== exp[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, mem_address, exp[i]); end
         if (end_reached !== (i == 3)) begin errors++; $display("FAIL wrap_end%0d got=%b exp=%b", i, end_reached, i == 3); end
         checks += 2;
      end
      if (pause !== !LOOP) begin errors++; $display("FAIL wrap_pause got=%b exp=%b", pause, !LOOP); end
      cycle(0, 0, 0, 0, 0);
      if (end_reached !== 1'b0) begin errors++; $display("FAIL wrap_end_single got=%b exp=0", end_reached); end
      checks += 2;
   endtask

   task automatic test_dir_change();
      logic [22:0] exp [3] = '{23'd6, 23'd6, 23'd5};
      do_reset();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      if (mem_address !== 23'd5) begin errors++; $display("FAIL dir_addr5 got=%h exp=5", mem_address); end
      checks++;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (mem_address !== exp[i]) begin errors++; $display("FAIL dir_addr%0d got=%h exp=%h", i, mem_address, exp[i]); end
         checks++;
      end
      if (reverse !== 1'b1) begin errors++; $display("FAIL dir_reverse got=%b exp=1", reverse); end
      checks++;
   endtask

   task automatic test_restart();
      do_reset();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 1, 1);
      if (mem_address !== E) begin errors++; $display("FAIL rst_addr got=%h exp=%h", mem_address, E); end
      if (pause !== 1'b0)    begin errors++; $display("FAIL rst_state got=%b exp=0", pause); end
      if (end_reached !== 1'b0) begin errors++; $display("FAIL rst_end got=%b exp=0", end_reached); end
      cycle(0, 0, 0, 1, 1);
      if (mem_address !== E) begin errors++; $display("FAIL rst_half got=%h exp=%h", mem_address, E); end
      cycle(0, 0, 0, 1, 1);
      if (mem_address !== E - 23'd1) begin errors++; $display("FAIL rst_step got=%h exp=%h", mem_address, E - 23'd1); end
      checks += 5;
   endtask

   task automatic test_play_pause();
      do_reset();
      cycle(1, 1, 0, 0, 0);
      if (pause !== 1'b1) begin errors++; $display("FAIL pp_pause got=%b exp=1", pause); end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
      if (mem_address !== S) begin errors++; $display("FAIL pp_addr got=%h exp=%h", mem_address, S); end
      checks += 2;
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 2 * 'h1234 + 1; i++) cycle(0, 0, 0, 0, 1);
      if (mem_address !== 23'h1234) begin errors++; $display("FAIL ar_setup got=%h exp=1234", mem_address); end
      #2 reset_n = 0;
      #1;
      if (mem_address !== S || pause !== 1'b1 || reverse !== 1'b0 || end_reached !== 1'b0) begin
         errors++; $display("FAIL ar_async got=%h/%b/%b/%b exp=%h/1/0/0", mem_address, pause, reverse, end_reached, S);
      end
      checks += 2;
      @(posedge clk); #1;
      reset_n = 1;
      model_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
      if (mem_address !== S || pause !== 1'b1) begin
         errors++; $display("FAIL ar_idle got=%h/%b exp=%h/1", mem_address, pause, S);
      end
      checks++;
   endtask

   task automatic test_random();
      bit d = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) d = !d;
         cycle($urandom_range(7) == 0, $urandom_range(31) == 0, $urandom_range(63) == 0, d,
               $urandom_range(1) == 1);
         if (mem_address !== S + 23'(m_off)) begin
            errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, mem_address, S + 23'(m_off));
         end
         if (pause !== !m_play)      begin errors++; $display("FAIL rnd_pause cyc=%0d got=%b exp=%b", i, pause, !m_play); end
         if (reverse !== m_rev)      begin errors++; $display("FAIL rnd_rev cyc=%0d got=%b exp=%b", i, reverse, m_rev); end
         if (end_reached !== m_end)  begin errors++; $display("FAIL rnd_end cyc=%0d got=%b exp=%b", i, end_reached, m_end); end
         checks += 4;
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_wrap();
      test_dir_change();
      test_restart();
      test_play_pause();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
